vga_if_timing: RTL and testbench

VGA interface timing generator and pixel output stage. Produces the raster counters, active-video enable and pixel coordinates consumed by the display pattern blocks (`VGA_IF_RGBEN_1`, `CURRENT_X/Y`, `DISPLAY_X/Y`). It takes back their registered `VGA_BUF_RGB`, aligns it with HSYNC/VSYNC/BLANK, and drives the DAC pins. It is the consumer side of the display block's interface and sits between the display blocks and the board VGA DAC.

---
 rtl/vga_if_pkg.sv | 61 ++++++
 rtl/vga_if_dly.sv | 30 +++
 rtl/vga_if_timing.sv | 145 ++++++++++++++
 tb/tb_vga_if_timing.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/vga_if_pkg.sv
// vga_if_pkg: shared constants for the VGA interface timing block.
//   CNT_W          - width of the raster counters and coordinate ports
//   vga_timing_t   - one complete timing set (porches, sync widths, polarities)
//   VGA_640X480_60 - 25.175 MHz mode
//   VGA_800X600_60 - 40 MHz mode (the block's default)
//   bar_rgb()      - colour for one of the eight vertical test bars
package vga_if_pkg;

  localparam int CNT_W    = 11;
  localparam int NUM_BARS = 8;

  typedef logic [23:0] rgb_t;

  typedef struct packed {
    int   h_disp;
    int   h_fp;
    int   h_sync;
    int   h_bp;
    int   v_disp;
    int   v_fp;
    int   v_sync;
    int   v_bp;
    logic hs_pol;
    logic vs_pol;
  } vga_timing_t;

  localparam vga_timing_t VGA_640X480_60 = '{
    h_disp: 640, h_fp: 16, h_sync: 96,  h_bp: 48,
    v_disp: 480, v_fp: 10, v_sync: 2,   v_bp: 33,
    hs_pol: 1'b0, vs_pol: 1'b0
  };

  localparam vga_timing_t VGA_800X600_60 = '{
    h_disp: 800, h_fp: 40, h_sync: 128, h_bp: 88,
    v_disp: 600, v_fp: 1,  v_sync: 4,   v_bp: 23,
    hs_pol: 1'b1, vs_pol: 1'b1
  };

  localparam rgb_t BAR_WHITE   = 24'hFFFFFF;
  localparam rgb_t BAR_YELLOW  = 24'hFFFF00;
  localparam rgb_t BAR_CYAN    = 24'h00FFFF;
  localparam rgb_t BAR_GREEN   = 24'h00FF00;
  localparam rgb_t BAR_MAGENTA = 24'hFF00FF;
  localparam rgb_t BAR_RED     = 24'hFF0000;
  localparam rgb_t BAR_BLUE    = 24'h0000FF;
  localparam rgb_t BAR_BLACK   = 24'h000000;

  function automatic rgb_t bar_rgb(input logic [2:0] idx);
    case (idx)
      3'd0:    return BAR_WHITE;
      3'd1:    return BAR_YELLOW;
      3'd2:    return BAR_CYAN;
      3'd3:    return BAR_GREEN;
      3'd4:    return BAR_MAGENTA;
      3'd5:    return BAR_RED;
      3'd6:    return BAR_BLUE;
      default: return BAR_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/vga_if_dly.sv
// vga_if_dly: N-deep, W-wide register delay line.
//   VGA_CLK  in     - clock
//   RST_N    in     - async active-low reset, every stage loads RST_VAL
//   din      in  W  - value entering the line
//   dout     out W  - din delayed by N clocks
module vga_if_dly #(
  parameter int             N       = 3,
  parameter int             W       = 1,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         VGA_CLK,
  input  logic         RST_N,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [N-1:0][W-1:0] sr;

  always_ff @(posedge VGA_CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < N; i++) sr[i] <= RST_VAL;
    end else begin
      sr[0] <= din;
      for (int i = 1; i < N; i++) sr[i] <= sr[i-1];
    end
  end

  assign dout = sr[N-1];

endmodule

// File: rtl/vga_if_timing.sv
// vga_if_timing: VGA raster timing generator and DAC output stage.
//   VGA_CLK, RST_N          - pixel clock, async active-low reset
//   VGA_BUF_RGB     in  24  - pixel from the display block, one cycle after CURRENT_X/Y
//   VGA_IF_RGBEN_1  out     - active-video enable (stage 1)
//   CURRENT_X/Y     out 11  - raster counters (stage 1, also valid in blanking)
//   DISPLAY_X/Y     out 11  - active resolution constants
//   VGA_HS/VS/BLANK_N/FRAME - pin controls, aligned with VGA_R/G/B (stage 3)
//   VGA_R/G/B       out 8   - DAC data, zero outside active video
// Build option: VGA_IF_TEST_PATTERN_EN replaces VGA_BUF_RGB with eight
// vertical colour bars derived from the delayed x coordinate.
// H_TOT and V_TOT must each fit in the 11-bit counters (<= 2047).
module vga_if_timing
  import vga_if_pkg::*;
#(
  parameter int   H_DISP = VGA_800X600_60.h_disp,
  parameter int   H_FP   = VGA_800X600_60.h_fp,
  parameter int   H_SYNC = VGA_800X600_60.h_sync,
  parameter int   H_BP   = VGA_800X600_60.h_bp,
  parameter int   V_DISP = VGA_800X600_60.v_disp,
  parameter int   V_FP   = VGA_800X600_60.v_fp,
  parameter int   V_SYNC = VGA_800X600_60.v_sync,
  parameter int   V_BP   = VGA_800X600_60.v_bp,
  parameter logic HS_POL = VGA_800X600_60.hs_pol,
  parameter logic VS_POL = VGA_800X600_60.vs_pol
) (
  input  logic             VGA_CLK,
  input  logic             RST_N,
  input  logic [23:0]      VGA_BUF_RGB,
  output logic             VGA_IF_RGBEN_1,
  output logic [CNT_W-1:0] CURRENT_X,
  output logic [CNT_W-1:0] CURRENT_Y,
  output logic [CNT_W-1:0] DISPLAY_X,
  output logic [CNT_W-1:0] DISPLAY_Y,
  output logic             VGA_HS,
  output logic             VGA_VS,
  output logic             VGA_BLANK_N,
  output logic [7:0]       VGA_R,
  output logic [7:0]       VGA_G,
  output logic [7:0]       VGA_B,
  output logic             VGA_FRAME
);

  localparam int H_TOT = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_DISP + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOT - 1);
  localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOT - 1);
  localparam logic [CNT_W-1:0] H_ACT   = CNT_W'(H_DISP);
  localparam logic [CNT_W-1:0] V_ACT   = CNT_W'(V_DISP);
  // Sync windows as [on, off): off is one past the last sync count.
  localparam logic [CNT_W-1:0] HS_ON   = CNT_W'(H_DISP + H_FP);
  localparam logic [CNT_W-1:0] HS_OFF  = CNT_W'(H_DISP + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_ON   = CNT_W'(V_DISP + V_FP);
  localparam logic [CNT_W-1:0] VS_OFF  = CNT_W'(V_DISP + V_FP + V_SYNC);

  // Pin-side control bundle, packed as {frame, blank_n, vs, hs}.
  localparam logic [3:0] CTL_RST = {1'b0, 1'b0, ~VS_POL, ~HS_POL};

  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic             active;
  logic [3:0]       ctl_raw, ctl_pin;
  logic [1:0]       vld_pipe;   // [0] stage 1 active, [1] stage 2 active
  rgb_t             pix_d, rgb_q;

  assign DISPLAY_X = H_ACT;
  assign DISPLAY_Y = V_ACT;

  // ---- raster counters ----
  always_ff @(posedge VGA_CLK or negedge RST_N) begin
    if (!RST_N) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CNT_W'(1);
    end else begin
      h_cnt <= h_cnt + CNT_W'(1);
    end
  end

  assign active = (h_cnt < H_ACT) && (v_cnt < V_ACT);

  always_comb begin
    ctl_raw    = CTL_RST;
    ctl_raw[0] = (h_cnt >= HS_ON && h_cnt < HS_OFF) ? HS_POL : ~HS_POL;
    ctl_raw[1] = (v_cnt >= VS_ON && v_cnt < VS_OFF) ? VS_POL : ~VS_POL;
    ctl_raw[2] = active;
    ctl_raw[3] = (h_cnt == '0) && (v_cnt == '0);
  end

  // ---- stage 1: coordinates and enable to the display block ----
  always_ff @(posedge VGA_CLK or negedge RST_N) begin
    if (!RST_N) begin
      vld_pipe  <= '0;
      CURRENT_X <= '0;
      CURRENT_Y <= '0;
    end else begin
      vld_pipe  <= {vld_pipe[0], active};
      CURRENT_X <= h_cnt;
      CURRENT_Y <= v_cnt;
    end
  end

  assign VGA_IF_RGBEN_1 = vld_pipe[0];

  // ---- stage 3: pixel source ----
`ifdef VGA_IF_TEST_PATTERN_EN
  logic [CNT_W-1:0] x_2;   // x lined up with stage 2
  int               bar_idx;

  always_ff @(posedge VGA_CLK or negedge RST_N) begin
    if (!RST_N) x_2 <= '0;
    else        x_2 <= CURRENT_X;
  end

  always_comb begin
    bar_idx = (int'(x_2) * NUM_BARS) / H_DISP;
    pix_d   = (bar_idx < NUM_BARS) ? bar_rgb(3'(bar_idx)) : BAR_BLACK;
  end
`else
  assign pix_d = VGA_BUF_RGB;
`endif

  always_ff @(posedge VGA_CLK or negedge RST_N) begin
    if (!RST_N) rgb_q <= '0;
    else        rgb_q <= vld_pipe[1] ? pix_d : '0;
  end

  assign {VGA_R, VGA_G, VGA_B} = rgb_q;

  // Controls are taken straight from the counters, so three registers put
  // them in the same cycle as the stage-3 RGB register.
  vga_if_dly #(.N(3), .W(4), .RST_VAL(CTL_RST)) u_ctl_dly (
    .VGA_CLK (VGA_CLK),
    .RST_N   (RST_N),
    .din     (ctl_raw),
    .dout    (ctl_pin)
  );

  assign VGA_HS      = ctl_pin[0];
  assign VGA_VS      = ctl_pin[1];
  assign VGA_BLANK_N = ctl_pin[2];
  assign VGA_FRAME   = ctl_pin[3];

endmodule

// File: tb/tb_vga_if_timing.sv
// Bench for vga_if_timing using a small raster so several full frames fit.
// Expected outputs come from the cycle count since reset release:
// raster position = count mod frame length, split into (h, v) by division.
module tb_vga_if_timing;

  localparam int TH_DISP = 16, TH_FP = 2, TH_SYNC = 3, TH_BP = 4;
  localparam int TV_DISP = 6,  TV_FP = 1, TV_SYNC = 2, TV_BP = 2;
  localparam logic THS_POL = 1'b1;
  localparam logic TVS_POL = 1'b0;
  localparam int HT    = TH_DISP + TH_FP + TH_SYNC + TH_BP;
  localparam int VT    = TV_DISP + TV_FP + TV_SYNC + TV_BP;
  localparam int FRAME = HT * VT;

  logic        VGA_CLK = 1'b0;
  logic        RST_N   = 1'b0;
  logic [23:0] VGA_BUF_RGB = '0;
  logic        VGA_IF_RGBEN_1;
  logic [10:0] CURRENT_X, CURRENT_Y, DISPLAY_X, DISPLAY_Y;
  logic        VGA_HS, VGA_VS, VGA_BLANK_N, VGA_FRAME;
  logic [7:0]  VGA_R, VGA_G, VGA_B;

  always #5 VGA_CLK = ~VGA_CLK;

  vga_if_timing #(
    .H_DISP(TH_DISP), .H_FP(TH_FP), .H_SYNC(TH_SYNC), .H_BP(TH_BP),
    .V_DISP(TV_DISP), .V_FP(TV_FP), .V_SYNC(TV_SYNC), .V_BP(TV_BP),
    .HS_POL(THS_POL), .VS_POL(TVS_POL)
  ) dut (
    .VGA_CLK        (VGA_CLK),
    .RST_N          (RST_N),
    .VGA_BUF_RGB    (VGA_BUF_RGB),
    .VGA_IF_RGBEN_1 (VGA_IF_RGBEN_1),
    .CURRENT_X      (CURRENT_X),
    .CURRENT_Y      (CURRENT_Y),
    .DISPLAY_X      (DISPLAY_X),
    .DISPLAY_Y      (DISPLAY_Y),
    .VGA_HS         (VGA_HS),
    .VGA_VS         (VGA_VS),
    .VGA_BLANK_N    (VGA_BLANK_N),
    .VGA_R          (VGA_R),
    .VGA_G          (VGA_G),
    .VGA_B          (VGA_B),
    .VGA_FRAME      (VGA_FRAME)
  );

  logic [23:0] pix_mem [VT][HT];
  int k;            // posedges since reset release
  int nchk, nerr;
  int nfr;          // observed VGA_FRAME pulses since release
  int px, py;       // coordinates the display block latched last cycle

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (k=%0d)", tag, got, exp, k);
    end
  endtask

  // Raster position reached n clocks after release.
  task automatic raster(input int n, output int h, output int v, output bit act);
    int p;
    p   = n % FRAME;
    h   = p % HT;
    v   = p / HT;
    act = (h < TH_DISP) && (v < TV_DISP);
  endtask

  function automatic logic [23:0] exp_pix(input int h, input int v);
`ifdef VGA_IF_TEST_PATTERN_EN
    logic [23:0] bars [8];
    bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    return bars[(h * 8) / TH_DISP];
`else
    return pix_mem[v][h];
`endif
  endfunction

  task automatic check_reset(input string why);
    chk({why, ".rgben"}, 32'(VGA_IF_RGBEN_1), 32'(0));
    chk({why, ".cx"},    32'(CURRENT_X), 32'(0));
    chk({why, ".cy"},    32'(CURRENT_Y), 32'(0));
    chk({why, ".hs"},    32'(VGA_HS), 32'(!THS_POL));
    chk({why, ".vs"},    32'(VGA_VS), 32'(!TVS_POL));
    chk({why, ".blank"}, 32'(VGA_BLANK_N), 32'(0));
    chk({why, ".frame"}, 32'(VGA_FRAME), 32'(0));
    chk({why, ".rgb"},   32'({VGA_R, VGA_G, VGA_B}), 32'(0));
    chk({why, ".dispx"}, 32'(DISPLAY_X), 32'(TH_DISP));
    chk({why, ".dispy"}, 32'(DISPLAY_Y), 32'(TV_DISP));
  endtask

  task automatic check_cycle();
    int h, v;
    bit a;
    if (k < 1) begin
      chk("rgben", 32'(VGA_IF_RGBEN_1), 32'(0));
      chk("cx", 32'(CURRENT_X), 32'(0));
      chk("cy", 32'(CURRENT_Y), 32'(0));
    end else begin
      raster(k - 1, h, v, a);
      chk("rgben", 32'(VGA_IF_RGBEN_1), 32'(a));
      chk("cx", 32'(CURRENT_X), 32'(h));
      chk("cy", 32'(CURRENT_Y), 32'(v));
    end
    if (k < 3) begin
      chk("hs0", 32'(VGA_HS), 32'(!THS_POL));
      chk("vs0", 32'(VGA_VS), 32'(!TVS_POL));
      chk("blank0", 32'(VGA_BLANK_N), 32'(0));
      chk("frame0", 32'(VGA_FRAME), 32'(0));
      chk("rgb0", 32'({VGA_R, VGA_G, VGA_B}), 32'(0));
    end else begin
      raster(k - 3, h, v, a);
      chk("hs", 32'(VGA_HS),
          32'((h >= TH_DISP + TH_FP && h < TH_DISP + TH_FP + TH_SYNC) ? THS_POL : !THS_POL));
      chk("vs", 32'(VGA_VS),
          32'((v >= TV_DISP + TV_FP && v < TV_DISP + TV_FP + TV_SYNC) ? TVS_POL : !TVS_POL));
      chk("blank", 32'(VGA_BLANK_N), 32'(a));
      chk("frame", 32'(VGA_FRAME), 32'(h == 0 && v == 0));
      chk("rgb", 32'({VGA_R, VGA_G, VGA_B}), 32'(a ? exp_pix(h, v) : 24'h0));
    end
  endtask

  // One clock: act as the display block just after the edge, check at negedge.
  task automatic step(input bit rst_hold);
    @(posedge VGA_CLK);
    #1;
    VGA_BUF_RGB = (px < HT && py < VT) ? pix_mem[py][px] : 24'h0;
    px = int'(CURRENT_X);
    py = int'(CURRENT_Y);
    if (!rst_hold) k++;
    @(negedge VGA_CLK);
    if (rst_hold) check_reset("rst");
    else          check_cycle();
    if (VGA_FRAME === 1'b1) nfr++;
  endtask

  function automatic int exp_frames(input int kmax);
    return (kmax < 3) ? 0 : (kmax - 3) / FRAME + 1;
  endfunction

  initial begin
    int run1, run2, gap;
    nchk = 0; nerr = 0; k = 0; nfr = 0; px = 0; py = 0;
    for (int y = 0; y < VT; y++)
      for (int x = 0; x < HT; x++)
        pix_mem[y][x] = 24'($urandom);

    // Power-up reset.
    RST_N = 1'b0;
    repeat (4) step(1'b1);

    // Release on a falling edge, then run several complete frames.
    RST_N = 1'b1; k = 0; nfr = 0;
    run1 = 3 * FRAME + 7;
    repeat (run1) step(1'b0);
    chk("frames1", 32'(nfr), 32'(exp_frames(run1)));

    // Wander to a random raster position, then reset mid-frame.
    gap = int'($urandom_range(FRAME - 1, 1));
    repeat (gap) step(1'b0);
    @(posedge VGA_CLK);
    #2 RST_N = 1'b0;
    #1 check_reset("async");
    repeat (int'($urandom_range(4, 2))) step(1'b1);

    // Restart from (0,0): first frame must be full length.
    RST_N = 1'b1; k = 0; nfr = 0;
    run2 = 2 * FRAME + 5;
    repeat (run2) step(1'b0);
    chk("frames2", 32'(nfr), 32'(exp_frames(run2)));

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
